bridge_1xn: RTL and testbench
=============================

# bridge_1xn

Parametrised 1-to-N data-side bus bridge between the CPU data port and N memory-mapped slaves (data SRAM, confreg, future peripherals). It decodes each request against per-slave base/mask windows and forwards it unchanged in the same cycle. It routes read data back after a configurable fixed slave read latency. Unmapped accesses are absorbed, return a fixed value, and are logged in a sticky error capture register with a saturating counter. It replaces the fixed two-slave bridge in the SoC top.

## Interface

- `N_SLAVE`, 2: number of slave ports, 1..8.
- `XLEN`, 32: address/data width.
- `RD_LAT`, 1: slave read latency in cycles, 1..4, identical for all slaves.
- `SLV_BASE`, {32'h1faf_0000, 32'h0000_0000}: packed N_SLAVE×XLEN window bases; slave i in bits [i*XLEN +: XLEN].
- `SLV_MASK`, {32'hffff_0000, 32'hffff_c000}: packed N_SLAVE×XLEN window masks, same packing.
- `UNMAP_RDATA`, 32'hdead_beef: read data returned for unmapped reads.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_data_en`  in  1  request valid this cycle.
- `cpu_data_wen`  in  4  byte write enables; all-zero means read.
- `cpu_data_addr`  in  XLEN  byte address.
- `cpu_data_wdata`  in  XLEN  write data.
- `cpu_data_rdata`  out  XLEN  read data, valid RD_LAT cycles after the read request.
- `slv_en`  out  N_SLAVE  per-slave request enable.
- `slv_wen`  out  4*N_SLAVE  per-slave byte enables.
- `slv_addr`  out  XLEN*N_SLAVE  per-slave address (copy of cpu_data_addr).
- `slv_wdata`  out  XLEN*N_SLAVE  per-slave write data (copy).
- `slv_rdata`  in  XLEN*N_SLAVE  per-slave read data.
- `err_clr`  in  1  clears error capture (one-cycle pulse).
- `err_valid`  out  1  sticky: an unmapped access has been seen.
- `err_addr`  out  XLEN  address of first unmapped access since last clear.
- `err_is_wr`  out  1  first unmapped access was a write.
- `err_cnt`  out  8  unmapped access count, saturating at 255.

## Operation

- Decode (combinational): hit[i] = ((cpu_data_addr & SLV_MASK[i]) == SLV_BASE[i]). On overlapping windows the lowest index wins; exactly one slave or none is selected.
- Forwarding: slv_en[sel] = cpu_data_en; slv_wen/addr/wdata for the selected slave are copies of CPU inputs. Non-selected slaves get en=0 and wen=0; their addr/wdata carry the CPU value.
- Unmapped request (en=1, no hit): no slave enabled. Writes are dropped. Reads return UNMAP_RDATA.
- Read return: RD_LAT-deep pipeline of {rd_valid, unmapped, idx[2:0]}. Stage 0 loads on every cycle: rd_valid = en & (wen==0).
- At the final stage, cpu_data_rdata = slv_rdata[idx] if mapped, UNMAP_RDATA if unmapped, 0 if not rd_valid. The output is combinational from the final stage and slv_rdata.
- Back-to-back reads every cycle are supported; each returns in order at exactly RD_LAT cycles.
- Error capture, for any unmapped request:
  - err_cnt increments, saturating at 255.
  - If err_valid=0: load err_addr and err_is_wr, and set err_valid.
  - Later errors do not overwrite err_addr or err_is_wr.
- err_clr zeros err_valid, err_addr, err_is_wr and err_cnt. If err_clr and an unmapped request occur in the same cycle, the new error is captured: err_valid=1, err_cnt=1.

## Timing

- Request path: zero latency, same cycle.
- Read data: valid in cycle T+RD_LAT for a read presented in cycle T.
- Error registers: update on the clock edge ending the offending cycle.
- Reset (asynchronous, active-low) clears:
  - the pipeline, so cpu_data_rdata reads 0;
  - err_valid=0, err_addr=0, err_is_wr=0, err_cnt=0.
- Reset asserted mid-flight: in-flight reads are discarded, and the first RD_LAT cycles after release return 0.
- Slave outputs stay combinational through reset.

## Structure

- Shared package `bridge_pkg`:
  - default window constants: DSRAM_BASE/MASK, CONF_BASE/MASK;
  - MAX_SLAVE=8;
  - the pipeline-entry struct {rd_valid, unmapped, idx}.
- Sub-module `bridge_rd_pipe`: parametrised RD_LAT shift register of pipeline entries with async active-low reset. The top instantiates it once. Decode, fan-out and error logic stay in `bridge_1xn`.

## Test plan

- N_SLAVE=2, RD_LAT=1. Write 0x1234_5678 to 0x0000_0010, then read it → slv_en=2'b01 on both cycles. slave0 rdata is routed to cpu_data_rdata the cycle after the read.
- Alternating reads to 0x1faf_0000 (slave1) and 0x0000_0004 (slave0) every cycle, RD_LAT=3 → each return arrives at exactly T+3 from the correct slave, in order.
- Read of 0x8000_0000 (unmapped) → slv_en=0. rdata=0xdead_beef next cycle. err_valid=1, err_addr=0x8000_0000, err_is_wr=0, err_cnt=1.
- Second unmapped write to 0x9000_0000 → err_addr unchanged, err_cnt=2. Then err_clr together with an unmapped write to 0xa000_0000 → err_addr=0xa000_0000, err_is_wr=1, err_cnt=1.
- 300 unmapped accesses → err_cnt saturates at 255.
- RD_LAT=2, issue a read, assert reset the next cycle → pipeline clears and cpu_data_rdata=0. After release, no stale data appears and err_cnt=0.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared definitions for the 1-to-N data-side bus bridge: default address windows
// and the read-return pipeline entry.
package bridge_pkg;

    localparam int MAX_SLAVE = 8;
    localparam int IDX_W     = $clog2(MAX_SLAVE);

    localparam logic [31:0] DSRAM_BASE = 32'h0000_0000;
    localparam logic [31:0] DSRAM_MASK = 32'hffff_c000;
    localparam logic [31:0] CONF_BASE  = 32'h1faf_0000;
    localparam logic [31:0] CONF_MASK  = 32'hffff_0000;

    typedef struct packed {
        logic             rd_valid;
        logic             unmapped;
        logic [IDX_W-1:0] idx;
    } rd_entry_t;

endpackage

// File: rtl/bridge_1xn_if.sv
// CPU data port plus flattened per-slave request/response buses of the bridge.
interface bridge_1xn_if #(
    parameter int N_SLAVE = 2,
    parameter int XLEN    = 32
);
    logic                      cpu_data_en;
    logic [3:0]                cpu_data_wen;
    logic [XLEN-1:0]           cpu_data_addr;
    logic [XLEN-1:0]           cpu_data_wdata;
    logic [XLEN-1:0]           cpu_data_rdata;
    logic [N_SLAVE-1:0]        slv_en;
    logic [4*N_SLAVE-1:0]      slv_wen;
    logic [XLEN*N_SLAVE-1:0]   slv_addr;
    logic [XLEN*N_SLAVE-1:0]   slv_wdata;
    logic [XLEN*N_SLAVE-1:0]   slv_rdata;

    // master: CPU side plus slave responders; slave: the bridge itself
    modport master (
        output cpu_data_en, cpu_data_wen, cpu_data_addr, cpu_data_wdata, slv_rdata,
        input  cpu_data_rdata, slv_en, slv_wen, slv_addr, slv_wdata
    );

    modport slave (
        input  cpu_data_en, cpu_data_wen, cpu_data_addr, cpu_data_wdata, slv_rdata,
        output cpu_data_rdata, slv_en, slv_wen, slv_addr, slv_wdata
    );
endinterface

// File: rtl/bridge_rd_pipe.sv
// Fixed-depth shift register carrying read-return routing info for RD_LAT cycles.
module bridge_rd_pipe
    import bridge_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  rd_entry_t din,
    output rd_entry_t dout
);

    rd_entry_t entry_p [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) entry_p[i] <= '0;
        end else begin
            entry_p[0] <= din;
            for (int i = 1; i < RD_LAT; i++) entry_p[i] <= entry_p[i-1];
        end
    end

    assign dout = entry_p[RD_LAT-1];

endmodule

// File: rtl/bridge_1xn.sv
// 1-to-N data bus bridge: window decode, same-cycle fan-out, fixed-latency read
// return and sticky capture of unmapped accesses.
module bridge_1xn
    import bridge_pkg::*;
#(
    parameter int                      N_SLAVE     = 2,
    parameter int                      XLEN        = 32,
    parameter int                      RD_LAT      = 1,
    parameter logic [N_SLAVE*XLEN-1:0] SLV_BASE    = {CONF_BASE, DSRAM_BASE},
    parameter logic [N_SLAVE*XLEN-1:0] SLV_MASK    = {CONF_MASK, DSRAM_MASK},
    parameter logic [XLEN-1:0]         UNMAP_RDATA = 32'hdead_beef
) (
    input  logic            clk,
    input  logic            reset,
    bridge_1xn_if.slave     bus,
    input  logic            err_clr,
    output logic            err_valid,
    output logic [XLEN-1:0] err_addr,
    output logic            err_is_wr,
    output logic [7:0]      err_cnt
);

    logic             sel_vld;
    logic [IDX_W-1:0] sel_idx;
    logic             unmapped;
    rd_entry_t        pipe_in;
    rd_entry_t        pipe_out;

    logic             nxt_valid;
    logic [XLEN-1:0]  nxt_addr;
    logic             nxt_is_wr;
    logic [7:0]       nxt_cnt;

    // Descending scan so the lowest matching window wins on overlap
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int i = N_SLAVE - 1; i >= 0; i--) begin
            if ((bus.cpu_data_addr & SLV_MASK[i*XLEN +: XLEN]) == SLV_BASE[i*XLEN +: XLEN]) begin
                sel_vld = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_SLAVE; i++) begin
            bus.slv_en[i]              = bus.cpu_data_en && sel_vld && (sel_idx == IDX_W'(i));
            bus.slv_wen[i*4 +: 4]      = (sel_vld && (sel_idx == IDX_W'(i))) ? bus.cpu_data_wen : 4'b0;
            bus.slv_addr[i*XLEN +: XLEN]  = bus.cpu_data_addr;
            bus.slv_wdata[i*XLEN +: XLEN] = bus.cpu_data_wdata;
        end
    end

    assign unmapped          = bus.cpu_data_en && !sel_vld;
    assign pipe_in.rd_valid  = bus.cpu_data_en && (bus.cpu_data_wen == 4'b0);
    assign pipe_in.unmapped  = !sel_vld;
    assign pipe_in.idx       = sel_idx;

    bridge_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk   (clk),
        .rst_n (reset),
        .din   (pipe_in),
        .dout  (pipe_out)
    );

    always_comb begin
        bus.cpu_data_rdata = '0;
        if (pipe_out.rd_valid) begin
            if (pipe_out.unmapped) begin
                bus.cpu_data_rdata = UNMAP_RDATA;
            end else begin
                for (int i = 0; i < N_SLAVE; i++) begin
                    if (pipe_out.idx == IDX_W'(i)) bus.cpu_data_rdata = bus.slv_rdata[i*XLEN +: XLEN];
                end
            end
        end
    end

    // Clear is applied first so an error in the same cycle is still captured
    always_comb begin
        nxt_valid = err_valid;
        nxt_addr  = err_addr;
        nxt_is_wr = err_is_wr;
        nxt_cnt   = err_cnt;
        if (err_clr) begin
            nxt_valid = 1'b0;
            nxt_addr  = '0;
            nxt_is_wr = 1'b0;
            nxt_cnt   = '0;
        end
        if (unmapped) begin
            if (!nxt_valid) begin
                nxt_valid = 1'b1;
                nxt_addr  = bus.cpu_data_addr;
                nxt_is_wr = (bus.cpu_data_wen != 4'b0);
            end
            if (nxt_cnt != 8'hff) nxt_cnt = nxt_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
            err_is_wr <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_valid <= nxt_valid;
            err_addr  <= nxt_addr;
            err_is_wr <= nxt_is_wr;
            err_cnt   <= nxt_cnt;
        end
    end

endmodule

// File: tb/tb_bridge_1xn.sv
// Bench for bridge_1xn: three instances (RD_LAT 1/2/3) share one stimulus and are
// checked every cycle against a request-history model.
module tb_bridge_1xn;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        clr;
    logic        pat_mode;
    logic [63:0] srd;
    int          cyc = 0;

    int n_chk  = 0;
    int n_fail = 0;

    logic        ev [1:3];
    logic [31:0] ea [1:3];
    logic        ew [1:3];
    logic [7:0]  ec [1:3];

    bridge_1xn_if #(.N_SLAVE(2), .XLEN(32)) if1 ();
    bridge_1xn_if #(.N_SLAVE(2), .XLEN(32)) if2 ();
    bridge_1xn_if #(.N_SLAVE(2), .XLEN(32)) if3 ();

    assign if1.cpu_data_en = en;  assign if1.cpu_data_wen = wen;  assign if1.cpu_data_addr = addr;
    assign if1.cpu_data_wdata = wdata;  assign if1.slv_rdata = srd;
    assign if2.cpu_data_en = en;  assign if2.cpu_data_wen = wen;  assign if2.cpu_data_addr = addr;
    assign if2.cpu_data_wdata = wdata;  assign if2.slv_rdata = srd;
    assign if3.cpu_data_en = en;  assign if3.cpu_data_wen = wen;  assign if3.cpu_data_addr = addr;
    assign if3.cpu_data_wdata = wdata;  assign if3.slv_rdata = srd;

    bridge_1xn #(.RD_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1), .err_clr(clr),
        .err_valid(ev[1]), .err_addr(ea[1]), .err_is_wr(ew[1]), .err_cnt(ec[1]));
    bridge_1xn #(.RD_LAT(2)) u_dut2 (.clk(clk), .reset(reset), .bus(if2), .err_clr(clr),
        .err_valid(ev[2]), .err_addr(ea[2]), .err_is_wr(ew[2]), .err_cnt(ec[2]));
    bridge_1xn #(.RD_LAT(3)) u_dut3 (.clk(clk), .reset(reset), .bus(if3), .err_clr(clr),
        .err_valid(ev[3]), .err_addr(ea[3]), .err_is_wr(ew[3]), .err_cnt(ec[3]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave responders: fixed words, or a per-slave tag plus cycle number
    function automatic logic [31:0] slave_val(input int i, input int c, input logic pm);
        if (pm) return {8'h10 + 8'(i), 24'(c)};
        return (i == 0) ? 32'h1234_5678 : 32'h1faf_1111;
    endfunction

    always_comb srd = {slave_val(1, cyc, pat_mode), slave_val(0, cyc, pat_mode)};

    // Window table: index 0 = data SRAM, index 1 = confreg; first match wins
    function automatic int decode(input logic [31:0] a);
        logic [31:0] base [2];
        logic [31:0] mask [2];
        base[0] = 32'h0000_0000; mask[0] = 32'hffff_c000;
        base[1] = 32'h1faf_0000; mask[1] = 32'hffff_0000;
        for (int i = 0; i < 2; i++) if ((a & mask[i]) == base[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    // Model state: read history per cycle (-2 none, -1 unmapped, else slave) and error regs
    int          hist_sel [0:4095];
    int          last_rst = -1;
    logic        m_valid = 1'b0;
    logic [31:0] m_addr  = '0;
    logic        m_wr    = 1'b0;
    int          m_cnt   = 0;

    function automatic logic [31:0] exp_rdata(input int lat);
        int k;
        k = cyc - lat;
        if (k < 0 || k <= last_rst || hist_sel[k] == -2) return 32'h0;
        if (hist_sel[k] == -1) return 32'hdead_beef;
        return slave_val(hist_sel[k], cyc, pat_mode);
    endfunction

    task automatic check_dut(input int j, input int lat, input logic [1:0] a_en, input logic [7:0] a_wen,
                             input logic [63:0] a_addr, input logic [63:0] a_wdata, input logic [31:0] a_rd);
        int          s;
        logic [1:0]  x_en;
        logic [7:0]  x_wen;
        s     = decode(addr);
        x_en  = '0;
        x_wen = '0;
        if (s == 0) begin x_en[0] = en; x_wen[3:0] = wen; end
        if (s == 1) begin x_en[1] = en; x_wen[7:4] = wen; end
        chk($sformatf("dut%0d slv_en", j),    64'(a_en),  64'(x_en));
        chk($sformatf("dut%0d slv_wen", j),   64'(a_wen), 64'(x_wen));
        chk($sformatf("dut%0d slv_addr", j),  a_addr,  {addr, addr});
        chk($sformatf("dut%0d slv_wdata", j), a_wdata, {wdata, wdata});
        chk($sformatf("dut%0d rdata", j),     64'(a_rd), 64'(exp_rdata(lat)));
        chk($sformatf("dut%0d err_valid", j), 64'(ev[j]), 64'(m_valid));
        chk($sformatf("dut%0d err_addr", j),  64'(ea[j]), 64'(m_addr));
        chk($sformatf("dut%0d err_is_wr", j), 64'(ew[j]), 64'(m_wr));
        chk($sformatf("dut%0d err_cnt", j),   64'(ec[j]), 64'(m_cnt));
    endtask

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            last_rst = cyc;
            m_valid  = 1'b0; m_addr = '0; m_wr = 1'b0; m_cnt = 0;
        end
        hist_sel[cyc] = (en && wen == 4'b0) ? decode(addr) : -2;
        check_dut(1, 1, if1.slv_en, if1.slv_wen, if1.slv_addr, if1.slv_wdata, if1.cpu_data_rdata);
        check_dut(2, 2, if2.slv_en, if2.slv_wen, if2.slv_addr, if2.slv_wdata, if2.cpu_data_rdata);
        check_dut(3, 3, if3.slv_en, if3.slv_wen, if3.slv_addr, if3.slv_wdata, if3.cpu_data_rdata);
        if (reset === 1'b1) begin
            if (clr) begin m_valid = 1'b0; m_addr = '0; m_wr = 1'b0; m_cnt = 0; end
            if (en && decode(addr) < 0) begin
                if (!m_valid) begin m_valid = 1'b1; m_addr = addr; m_wr = (wen != 4'b0); end
                if (m_cnt < 255) m_cnt++;
            end
        end
    end

    task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] d, input logic c);
        @(posedge clk);
        #1;
        en = e; wen = w; addr = a; wdata = d; clr = c;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int t0;
        reset = 1'b0; en = 1'b0; wen = 4'b0; addr = '0; wdata = '0; clr = 1'b0; pat_mode = 1'b0;
        @(negedge clk);
        chk("reset rdata", 64'(if1.cpu_data_rdata), 64'h0);
        chk("reset err_valid", 64'(ev[1]), 64'h0);
        chk("reset err_cnt", 64'(ec[3]), 64'h0);
        @(posedge clk); #1; reset = 1'b1;

        step(1'b1, 4'hf, 32'h0000_0010, 32'h1234_5678, 1'b0);
        @(negedge clk);
        chk("write slv_en", 64'(if1.slv_en), 64'h1);
        chk("write slv_wen", 64'(if1.slv_wen), 64'h0f);
        step(1'b1, 4'h0, 32'h0000_0010, 32'h0, 1'b0);
        @(negedge clk);
        chk("read slv_en", 64'(if1.slv_en), 64'h1);
        step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("read return", 64'(if1.cpu_data_rdata), 64'h1234_5678);

        step(1'b1, 4'h0, 32'h8000_0000, 32'h0, 1'b0);
        @(negedge clk);
        chk("unmapped slv_en", 64'(if1.slv_en), 64'h0);
        step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("unmapped rdata", 64'(if1.cpu_data_rdata), 64'hdead_beef);
        chk("first err_valid", 64'(ev[1]), 64'h1);
        chk("first err_addr", 64'(ea[1]), 64'h8000_0000);
        chk("first err_is_wr", 64'(ew[1]), 64'h0);
        chk("first err_cnt", 64'(ec[1]), 64'h1);

        step(1'b1, 4'hf, 32'h9000_0000, 32'h5555_aaaa, 1'b0);
        step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("second err_addr", 64'(ea[1]), 64'h8000_0000);
        chk("second err_cnt", 64'(ec[1]), 64'h2);

        step(1'b1, 4'h3, 32'ha000_0000, 32'h0, 1'b1);
        step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("clr+err err_addr", 64'(ea[2]), 64'ha000_0000);
        chk("clr+err err_is_wr", 64'(ew[2]), 64'h1);
        chk("clr+err err_cnt", 64'(ec[2]), 64'h1);

        pat_mode = 1'b1;
        t0 = 0;
        for (int k = 0; k < 11; k++) begin
            if (k < 8) step(1'b1, 4'h0, (k % 2 == 0) ? 32'h1faf_0000 : 32'h0000_0004, 32'h0, 1'b0);
            else       step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
            if (k == 0) t0 = cyc;
            @(negedge clk);
            if (k == 3) chk("lat3 slave1 return", 64'(if3.cpu_data_rdata), 64'({8'h11, 24'(t0 + 3)}));
            if (k == 4) chk("lat3 slave0 return", 64'(if3.cpu_data_rdata), 64'({8'h10, 24'(t0 + 4)}));
        end

        for (int k = 0; k < 300; k++)
            step(1'b1, (k % 2 == 1) ? 4'h1 : 4'h0, 32'hc000_0000 + 32'(k * 4), 32'h0, 1'b0);
        step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("saturated err_cnt", 64'(ec[1]), 64'd255);
        chk("saturated err_addr", 64'(ea[1]), 64'ha000_0000);

        step(1'b1, 4'h0, 32'h0000_0008, 32'h0, 1'b0);
        @(posedge clk); #1; reset = 1'b0; en = 1'b0;
        @(negedge clk);
        chk("midflight rdata", 64'(if2.cpu_data_rdata), 64'h0);
        chk("midflight err_cnt", 64'(ec[2]), 64'h0);
        @(posedge clk); #1; reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
            @(negedge clk);
            chk("post-reset stale rdata", 64'(if2.cpu_data_rdata), 64'h0);
            chk("post-reset err_cnt", 64'(ec[2]), 64'h0);
        end

        step(1'b1, 4'h0, 32'h1faf_0010, 32'h0, 1'b0);
        repeat (4) step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
